// File: rtl/multicycle_controller.sv
// Control unit for the multicycle RV32I-subset datapath.
// A Moore main FSM sequences each instruction and drives the datapath enables
// and mux selects. The ALU function code, the immediate select and the branch
// PC enable are combinational. The unit also keeps a retired-instruction
// counter and a sticky illegal-opcode flag.
module multicycle_controller #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             zero,
  output logic             pc_write,
  output logic             adr_src,
  output logic             mem_write,
  output logic             ir_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       imm_src,
  output logic             reg_write,
  output logic [2:0]       alu_control,
  output logic [CNT_W-1:0] instret,
  output logic             illegal
);

  localparam logic [6:0] OpLw   = 7'b0000011;
  localparam logic [6:0] OpSw   = 7'b0100011;
  localparam logic [6:0] OpR    = 7'b0110011;
  localparam logic [6:0] OpI    = 7'b0010011;
  localparam logic [6:0] OpBeq  = 7'b1100011;
  localparam logic [6:0] OpJal  = 7'b1101111;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecuteR,
    StExecuteI,
    StAluWb,
    StBeq,
    StJal
  } state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0] instret_q, instret_d;
  logic             illegal_q, illegal_d;

  // Moore outputs before reset gating
  logic       pcupdate;
  logic       branch;
  logic [1:0] aluop;
  logic       ir_write_raw;
  logic       mem_write_raw;
  logic       reg_write_raw;

  logic       op_legal;
  logic       retire;
  logic       take_illegal;

  // Opcode legality check
  always_comb begin
    unique case (op)
      OpLw, OpSw, OpR, OpI, OpBeq, OpJal: op_legal = 1'b1;
      default:                            op_legal = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:  state_d = StDecode;
      StDecode: begin
        unique case (op)
          OpLw, OpSw: state_d = StMemAdr;
          OpR:        state_d = StExecuteR;
          OpI:        state_d = StExecuteI;
          OpBeq:      state_d = StBeq;
          OpJal:      state_d = StJal;
          default:    state_d = StFetch;
        endcase
      end
      // Only lw and sw reach MemAdr; anything that is not lw is treated as sw.
      StMemAdr:   state_d = (op == OpLw) ? StMemRead : StMemWrite;
      StMemRead:  state_d = StMemWb;
      StExecuteR: state_d = StAluWb;
      StExecuteI: state_d = StAluWb;
      StJal:      state_d = StAluWb;
      StMemWb:    state_d = StFetch;
      StMemWrite: state_d = StFetch;
      StAluWb:    state_d = StFetch;
      StBeq:      state_d = StFetch;
      default:    state_d = StFetch;
    endcase
  end

  // Per-state Moore outputs
  always_comb begin
    pcupdate      = 1'b0;
    branch        = 1'b0;
    aluop         = 2'b00;
    ir_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    adr_src       = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    unique case (state_q)
      StFetch: begin
        ir_write_raw = 1'b1;
        alu_src_b    = 2'b10;
        result_src   = 2'b10;
        pcupdate     = 1'b1;
      end
      StDecode: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      StMemAdr: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      StMemRead: begin
        adr_src = 1'b1;
      end
      StMemWb: begin
        result_src    = 2'b01;
        reg_write_raw = 1'b1;
      end
      StMemWrite: begin
        adr_src       = 1'b1;
        mem_write_raw = 1'b1;
      end
      StExecuteR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b00;
        aluop     = 2'b10;
      end
      StExecuteI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        aluop     = 2'b10;
      end
      StAluWb: begin
        reg_write_raw = 1'b1;
      end
      StBeq: begin
        alu_src_a = 2'b10;
        aluop     = 2'b01;
        branch    = 1'b1;
      end
      StJal: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pcupdate  = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Write enables are suppressed while reset is held, even mid-instruction
  always_comb begin
    pc_write  = ~reset & (pcupdate | (branch & zero));
    ir_write  = ~reset & ir_write_raw;
    mem_write = ~reset & mem_write_raw;
    reg_write = ~reset & reg_write_raw;
  end

  // ALU function decode; sub only for R-type (op[5]) with funct7b5 set
  always_comb begin
    alu_control = 3'b000;
    unique case (aluop)
      2'b00: alu_control = 3'b000;
      2'b01: alu_control = 3'b001;
      2'b10: begin
        unique case (funct3)
          3'b000:  alu_control = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alu_control = 3'b101;
          3'b110:  alu_control = 3'b011;
          3'b111:  alu_control = 3'b010;
          default: alu_control = 3'b000;
        endcase
      end
      default: alu_control = 3'b000;
    endcase
  end

  // Immediate format select follows the opcode in every state
  always_comb begin
    imm_src = 2'b00;
    unique case (op)
      OpSw:    imm_src = 2'b01;
      OpBeq:   imm_src = 2'b10;
      OpJal:   imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  // Retirement and illegal-opcode detection plus their next-state values
  always_comb begin
    retire       = (state_q == StMemWb) || (state_q == StMemWrite) ||
                   (state_q == StAluWb) || (state_q == StBeq);
    take_illegal = (state_q == StDecode) && !op_legal;
    instret_d    = retire ? instret_q + CNT_W'(1) : instret_q;
    illegal_d    = illegal_q | take_illegal;
  end

  // Counter and sticky flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      instret_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      instret_q <= instret_d;
      illegal_q <= illegal_d;
    end
  end

  assign instret = instret_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller. The reference is a per-opcode
// table of expected per-cycle control records, expanded into a queue when an
// instruction is issued and consumed one record per clock.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  op = 7'b0110011;
  logic [2:0]  funct3 = 3'b000;
  logic        funct7b5 = 1'b0;
  logic        zero = 1'b0;

  logic        pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0]  result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0]  alu_control;
  logic [31:0] instret;

  logic        pc_write4, adr_src4, mem_write4, ir_write4, reg_write4, illegal4;
  logic [1:0]  result_src4, alu_src_a4, alu_src_b4, imm_src4;
  logic [2:0]  alu_control4;
  logic [3:0]  instret4;

  always #5 clk = ~clk;

  multicycle_controller #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_src(imm_src), .reg_write(reg_write), .alu_control(alu_control),
    .instret(instret), .illegal(illegal)
  );

  multicycle_controller #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .pc_write(pc_write4), .adr_src(adr_src4), .mem_write(mem_write4), .ir_write(ir_write4),
    .result_src(result_src4), .alu_src_a(alu_src_a4), .alu_src_b(alu_src_b4),
    .imm_src(imm_src4), .reg_write(reg_write4), .alu_control(alu_control4),
    .instret(instret4), .illegal(illegal4)
  );

  localparam logic [6:0] OLw = 7'b0000011, OSw = 7'b0100011, OR = 7'b0110011;
  localparam logic [6:0] OI = 7'b0010011, OBeq = 7'b1100011, OJal = 7'b1101111;

  // kind: 0 = add, 1 = sub, 2 = decode from funct fields
  typedef struct packed {
    logic pcupd, branch, adr, mw, irw, rw, retire, ill;
    logic [1:0] res, srca, srcb, kind;
  } cyc_t;

  cyc_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int unsigned m_instret = 0;
  logic m_illegal = 1'b0;
  int   zero_mode = 0;  // 0 random, 1 force high, 2 force low
  int   obs_n = 0;
  logic [2:0] obs_alu [0:15];
  logic       obs_pcw [0:15];
  logic       obs_adr [0:15];
  logic       obs_mw  [0:15];
  logic       obs_irw [0:15];
  logic       obs_rw  [0:15];
  logic [1:0] obs_res [0:15];
  logic [1:0] obs_srcb[0:15];
  logic [1:0] obs_imm [0:15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic cyc_t c(input logic pcupd, branch, adr, mw, irw, rw, retire, ill,
                             input logic [1:0] res, srca, srcb, kind);
    c = '{pcupd, branch, adr, mw, irw, rw, retire, ill, res, srca, srcb, kind};
  endfunction

  function automatic logic legal(input logic [6:0] o);
    return (o == OLw) || (o == OSw) || (o == OR) || (o == OI) || (o == OBeq) || (o == OJal);
  endfunction

  function automatic logic [2:0] exp_alu(input logic [1:0] kind, input logic [6:0] o,
                                         input logic [2:0] f3, input logic f7);
    if (kind == 2'd0) return 3'b000;
    if (kind == 2'd1) return 3'b001;
    case (f3)
      3'b000:  return (o == OR && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] exp_imm(input logic [6:0] o);
    if (o == OSw) return 2'b01;
    if (o == OBeq) return 2'b10;
    if (o == OJal) return 2'b11;
    return 2'b00;
  endfunction

  // Expand one instruction into its expected cycle records
  task automatic build(input logic [6:0] o);
    cyc_t alu_wb;
    cyc_t mem_adr;
    alu_wb  = c(0, 0, 0, 0, 0, 1, 1, 0, 2'd0, 2'd0, 2'd0, 2'd0);
    mem_adr = c(0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 2'd0);
    exp_q.push_back(c(1, 0, 0, 0, 1, 0, 0, 0, 2'd2, 2'd0, 2'd2, 2'd0));
    exp_q.push_back(c(0, 0, 0, 0, 0, 0, 0, !legal(o), 2'd0, 2'd1, 2'd1, 2'd0));
    case (o)
      OLw: begin
        exp_q.push_back(mem_adr);
        exp_q.push_back(c(0, 0, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0));
        exp_q.push_back(c(0, 0, 0, 0, 0, 1, 1, 0, 2'd1, 2'd0, 2'd0, 2'd0));
      end
      OSw: begin
        exp_q.push_back(mem_adr);
        exp_q.push_back(c(0, 0, 1, 1, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0, 2'd0));
      end
      OR: begin
        exp_q.push_back(c(0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 2'd2));
        exp_q.push_back(alu_wb);
      end
      OI: begin
        exp_q.push_back(c(0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 2'd2));
        exp_q.push_back(alu_wb);
      end
      OBeq: exp_q.push_back(c(0, 1, 0, 0, 0, 0, 1, 0, 2'd0, 2'd2, 2'd0, 2'd1));
      OJal: begin
        exp_q.push_back(c(1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd2, 2'd0));
        exp_q.push_back(alu_wb);
      end
      default: begin
      end
    endcase
  endtask

  // One clock: compare at negedge+1, then advance the model at posedge
  task automatic step();
    cyc_t e;
    zero = (zero_mode == 0) ? 1'($urandom_range(0, 1)) : (zero_mode == 1);
    #1;
    if (obs_n < 16) begin
      obs_alu[obs_n] = alu_control; obs_pcw[obs_n] = pc_write; obs_adr[obs_n] = adr_src;
      obs_mw[obs_n] = mem_write; obs_irw[obs_n] = ir_write; obs_rw[obs_n] = reg_write;
      obs_res[obs_n] = result_src; obs_srcb[obs_n] = alu_src_b; obs_imm[obs_n] = imm_src;
    end
    obs_n++;
    check("imm_src", 32'(imm_src), 32'(exp_imm(op)));
    if (reset) begin
      check("rst_pc_write", 32'(pc_write), 0);
      check("rst_ir_write", 32'(ir_write), 0);
      check("rst_mem_write", 32'(mem_write), 0);
      check("rst_reg_write", 32'(reg_write), 0);
    end else begin
      check("instret", instret, m_instret);
      check("instret4", 32'(instret4), m_instret % 16);
      check("illegal", 32'(illegal), 32'(m_illegal));
      if (exp_q.size() == 0) begin
        check("model_queue_empty", 0, 1);
      end else begin
        e = exp_q[0];
        check("pc_write", 32'(pc_write), 32'(e.pcupd | (e.branch & zero)));
        check("adr_src", 32'(adr_src), 32'(e.adr));
        check("mem_write", 32'(mem_write), 32'(e.mw));
        check("ir_write", 32'(ir_write), 32'(e.irw));
        check("reg_write", 32'(reg_write), 32'(e.rw));
        check("result_src", 32'(result_src), 32'(e.res));
        check("alu_src_a", 32'(alu_src_a), 32'(e.srca));
        check("alu_src_b", 32'(alu_src_b), 32'(e.srcb));
        check("alu_control", 32'(alu_control), 32'(exp_alu(e.kind, op, funct3, funct7b5)));
      end
    end
    @(posedge clk);
    if (reset) begin
      exp_q.delete();
      m_instret = 0;
      m_illegal = 1'b0;
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.retire) m_instret++;
      if (e.ill) m_illegal = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic do_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    op = o; funct3 = f3; funct7b5 = f7;
    obs_n = 0;
    build(o);
    while (exp_q.size() > 0 && obs_n < 12) step();
    if (obs_n >= 12) check("instr_cycle_budget", 32'(obs_n), 5);
  endtask

  initial begin
    @(negedge clk);
    reset = 1'b1;
    step(); step();
    reset = 1'b0;

    do_instr(OR, 3'b000, 1'b1);
    check("sub_cpi", 32'(obs_n), 4);
    check("sub_alu", 32'(obs_alu[2]), 32'h1);
    check("sub_rw", 32'(obs_rw[3]), 1);
    check("sub_instret", instret, 1);

    do_instr(OI, 3'b000, 1'b1); check("addi_alu", 32'(obs_alu[2]), 32'h0);
    do_instr(OI, 3'b010, 1'b0); check("slti_alu", 32'(obs_alu[2]), 32'h5);
    do_instr(OI, 3'b110, 1'b0); check("ori_alu", 32'(obs_alu[2]), 32'h3);
    do_instr(OI, 3'b111, 1'b0); check("andi_alu", 32'(obs_alu[2]), 32'h2);

    do_instr(OLw, 3'b010, 1'b0);
    check("lw_cpi", 32'(obs_n), 5);
    check("lw_memread_adr", 32'(obs_adr[3]), 1);
    check("lw_memwb_res", 32'(obs_res[4]), 1);
    check("lw_imm", 32'(obs_imm[2]), 0);
    do_instr(OSw, 3'b010, 1'b0);
    check("sw_cpi", 32'(obs_n), 4);
    check("sw_mw", 32'(obs_mw[3]), 1);
    check("sw_mw_memadr", 32'(obs_mw[2]), 0);
    check("sw_imm", 32'(obs_imm[2]), 1);

    zero_mode = 1;
    do_instr(OBeq, 3'b000, 1'b0);
    check("beq_taken_pcw", 32'(obs_pcw[2]), 1);
    check("beq_alu", 32'(obs_alu[2]), 32'h1);
    check("beq_cpi", 32'(obs_n), 3);
    zero_mode = 2;
    do_instr(OBeq, 3'b000, 1'b0);
    check("beq_not_taken_pcw", 32'(obs_pcw[2]), 0);
    check("beq_cpi2", 32'(obs_n), 3);
    zero_mode = 0;
    do_instr(OJal, 3'b000, 1'b0);
    check("jal_pcw", 32'(obs_pcw[2]), 1);
    check("jal_rw", 32'(obs_rw[3]), 1);
    check("jal_imm", 32'(obs_imm[2]), 3);
    check("instret_before_illegal", instret, 10);

    do_instr(7'b1111111, 3'b000, 1'b0);
    check("illegal_cpi", 32'(obs_n), 2);
    check("illegal_set", 32'(illegal), 1);
    check("illegal_instret", instret, 10);
    do_instr(OR, 3'b111, 1'b0);
    check("illegal_sticky", 32'(illegal), 1);

    // Reset held for two cycles while a store sits in MemWrite
    op = OSw; funct3 = 3'b010; funct7b5 = 1'b0;
    build(OSw);
    obs_n = 0;
    step(); step(); step();
    reset = 1'b1;
    step();
    check("rst_midstore_mw", 32'(obs_mw[3]), 0);
    step();
    reset = 1'b0;
    do_instr(OR, 3'b000, 1'b0);
    check("post_rst_irw", 32'(obs_irw[0]), 1);
    check("post_rst_pcw", 32'(obs_pcw[0]), 1);
    check("post_rst_srcb", 32'(obs_srcb[0]), 2);
    check("post_rst_illegal", 32'(illegal), 0);
    check("post_rst_instret", instret, 1);

    for (int i = 0; i < 15; i++) do_instr(OR, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    check("wrap_instret4", 32'(instret4), 0);
    check("wrap_instret32", instret, 16);

    for (int i = 0; i < 300; i++) begin
      logic [6:0] o;
      case ($urandom_range(0, 7))
        0: o = OLw;
        1: o = OSw;
        2: o = OR;
        3: o = OI;
        4: o = OBeq;
        5: o = OJal;
        default: o = 7'($urandom_range(0, 127));
      endcase
      do_instr(o, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
